// File: rtl/reg_bank_arbiter_if.sv
// Request/grant bus between the requesters and the shared register bank arbiter.
// Every requester owns one slice of req/we/addr/wdata; gnt, ack, rdata and busy are shared.
interface reg_bank_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [N_REQ-1:0]       req;
   logic [N_REQ-1:0]       we;
   logic [N_REQ*AW-1:0]    addr;
   logic [N_REQ*WIDTH-1:0] wdata;
   logic [N_REQ-1:0]       gnt;
   logic                   ack;
   logic [WIDTH-1:0]       rdata;
   logic                   busy;

   modport master (
      output req, we, addr, wdata,
      input  gnt, ack, rdata, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, ack, rdata, busy
   );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter giving N_REQ requesters single-access turns at a shared DEPTH x WIDTH
// register bank; each turn is IDLE -> GRANT -> DONE with a one-cycle ack.
module reg_bank_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   reg_bank_arbiter_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    win_q, win_d;
   logic [PW-1:0]    pick, pick_hi, pick_any, win_next;
   logic             hit_hi, hit_any;
   logic             wr_en;
   logic [AW-1:0]    acc_addr;
   logic [WIDTH-1:0] acc_wdata;
   logic [WIDTH-1:0] bank [DEPTH];

   // First requester at or above ptr wins; otherwise the wrap-around falls to the lowest one.
   always_comb begin
      pick_hi  = '0;
      pick_any = '0;
      hit_hi   = 1'b0;
      hit_any  = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (bus.req[i]) begin
            if (!hit_any) begin
               pick_any = PW'(i);
               hit_any  = 1'b1;
            end
            if (!hit_hi && i >= 32'(ptr_q)) begin
               pick_hi = PW'(i);
               hit_hi  = 1'b1;
            end
         end
      end
      pick = hit_hi ? pick_hi : pick_any;
   end

   assign win_next  = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
   assign acc_addr  = bus.addr[win_q * AW +: AW];
   assign acc_wdata = bus.wdata[win_q * WIDTH +: WIDTH];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ack_d   = 1'b0;
      rdata_d = rdata_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               win_d   = pick;
               gnt_d   = N_REQ'(1) << pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (bus.req[win_q]) begin
               ack_d   = 1'b1;
               state_d = DONE;
               if (bus.we[win_q]) wr_en   = 1'b1;
               else               rdata_d = bank[acc_addr];
            end else begin
               gnt_d   = '0;
               ptr_d   = win_next;
               state_d = IDLE;
            end
         end
         DONE: begin
            if (!bus.req[win_q]) begin
               gnt_d   = '0;
               ptr_d   = win_next;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         if (wr_en) bank[acc_addr] <= acc_wdata;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios with literal expectations, then random
// requester traffic compared every cycle against a transaction-level owner/age model.
module tb_reg_bank_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int AW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_bank_arbiter_if #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();
   reg_bank_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the bank (-1 = nobody) and how many edges since the grant.
   int           owner = -1;
   int           age   = 0;
   int           ptr_m = 0;
   int           ma;
   logic [W-1:0] bank_m [D];
   logic [W-1:0] rdata_m = '0;
   logic [N-1:0] gnt_m   = '0;
   logic         ack_m   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner = -1; age = 0; ptr_m = 0; rdata_m = '0; gnt_m = '0; ack_m = 1'b0;
         for (int k = 0; k < D; k++) bank_m[k] = '0;
      end else begin
         ack_m = 1'b0;
         if (owner < 0) begin
            for (int k = 0; k < N; k++)
               if (owner < 0 && bus.req[(ptr_m + k) % N]) owner = (ptr_m + k) % N;
            if (owner >= 0) begin
               age = 0;
               gnt_m = '0;
               gnt_m[owner] = 1'b1;
            end
         end else if (age == 0 && bus.req[owner]) begin
            ack_m = 1'b1;
            age = 1;
            ma = int'(bus.addr[owner*AW +: AW]);
            if (bus.we[owner]) bank_m[ma] = bus.wdata[owner*W +: W];
            else               rdata_m = bank_m[ma];
         end else if (!bus.req[owner]) begin
            ptr_m = (owner + 1) % N;
            owner = -1;
            gnt_m = '0;
         end
      end
   end

   logic ack_prev = 1'b0;
   bit   chk_en   = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("gnt",        32'(bus.gnt),          32'(gnt_m));
         chk("ack",        32'(bus.ack),          32'(ack_m));
         chk("rdata",      32'(bus.rdata),        32'(rdata_m));
         chk("busy",       32'(bus.busy),         32'(owner >= 0));
         chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'(1));
         chk("ack_repeat", 32'(ack_prev & bus.ack), 32'(0));
         ack_prev = bus.ack;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_slot(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
      bus.req[i]            = r;
      bus.we[i]             = w;
      bus.addr[i*AW +: AW]  = a;
      bus.wdata[i*W +: W]   = d;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   int           order[$];
   int           exp33[5] = '{0, 1, 2, 3, 0};
   int           nack;
   logic [N-1:0] pg;
   logic [N-1:0] done_r;

   initial begin
      rst_n = 1'b0;
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
      chk_en = 1'b1;
      step();
      chk("rst_gnt",   32'(bus.gnt),   32'h0);
      chk("rst_ack",   32'(bus.ack),   32'h0);
      chk("rst_busy",  32'(bus.busy),  32'h0);
      chk("rst_rdata", 32'(bus.rdata), 32'h0);
      step();
      rst_n = 1'b1;

      // Write 0xA5 to addr 2 through requester 1, then read it back.
      set_slot(1, 1'b1, 1'b1, 2'd2, 8'hA5);
      step();
      chk("t32_gnt",  32'(bus.gnt),  32'h2);
      chk("t32_busy", 32'(bus.busy), 32'h1);
      chk("t32_ack0", 32'(bus.ack),  32'h0);
      step();
      chk("t32_ack1", 32'(bus.ack),  32'h1);
      bus.req[1] = 1'b0;
      step();
      chk("t32_gnt_clr", 32'(bus.gnt), 32'h0);
      set_slot(1, 1'b1, 1'b0, 2'd2, 8'h00);
      step();
      step();
      chk("t32_rd_ack",   32'(bus.ack),   32'h1);
      chk("t32_rd_rdata", 32'(bus.rdata), 32'hA5);
      bus.req = '0;
      step(); step();

      // All four requesting; each drops after its ack and re-raises once released.
      do_reset();
      bus.we = '0;
      bus.req = '1;
      nack = 0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         pg = bus.gnt;
         step();
         if (bus.ack) begin
            nack++;
            bus.req = bus.req & ~bus.gnt;
         end
         if (pg == '0 && bus.gnt != '0)
            for (int k = 0; k < N; k++) if (bus.gnt[k]) order.push_back(k);
         if (pg != '0 && bus.gnt == '0) bus.req = '1;
      end
      chk("t33_grants", 32'(order.size()), 32'd5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("t33_order%0d", k), 32'((k < order.size()) ? order[k] : -1), 32'(exp33[k]));
      chk("t33_acks", 32'(nack), 32'd4);
      bus.req = '0;
      step(); step(); step();

      // Serve requester 2, then 3 and 0 together: 3 first, then 0.
      do_reset();
      set_slot(2, 1'b1, 1'b0, 2'd0, 8'h00);
      step();
      chk("t34_gnt2", 32'(bus.gnt), 32'h4);
      step();
      bus.req = '0;
      step();
      bus.req = 4'b1001;
      step();
      chk("t34_gnt3", 32'(bus.gnt), 32'h8);
      step();
      chk("t34_ack3", 32'(bus.ack), 32'h1);
      bus.req[3] = 1'b0;
      step();
      chk("t34_clr", 32'(bus.gnt), 32'h0);
      step();
      chk("t34_gnt0", 32'(bus.gnt), 32'h1);
      step();
      bus.req = '0;
      step(); step();

      // Abort: requester 0 withdraws a write during GRANT.
      do_reset();
      set_slot(3, 1'b1, 1'b1, 2'd3, 8'h11);
      step(); step();
      bus.req = '0;
      step();
      set_slot(0, 1'b1, 1'b1, 2'd3, 8'h5A);
      step();
      chk("t35_gnt", 32'(bus.gnt), 32'h1);
      bus.req[0] = 1'b0;
      step();
      chk("t35_gnt_clr", 32'(bus.gnt),  32'h0);
      chk("t35_no_ack",  32'(bus.ack),  32'h0);
      chk("t35_busy",    32'(bus.busy), 32'h0);
      set_slot(1, 1'b1, 1'b0, 2'd3, 8'h00);
      bus.req[0] = 1'b1;
      step();
      chk("t35_ptr", 32'(bus.gnt), 32'h2);
      step();
      chk("t35_ack",   32'(bus.ack),   32'h1);
      chk("t35_rdata", 32'(bus.rdata), 32'h11);
      bus.req = '0;
      step(); step();

      // Reset during the GRANT cycle of a write to addr 1.
      do_reset();
      set_slot(0, 1'b1, 1'b1, 2'd1, 8'h77);
      step();
      chk("t36_gnt", 32'(bus.gnt), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t36_gnt_async",  32'(bus.gnt),  32'h0);
      chk("t36_ack_async",  32'(bus.ack),  32'h0);
      chk("t36_busy_async", 32'(bus.busy), 32'h0);
      bus.req = '0;
      step();
      rst_n = 1'b1;
      set_slot(0, 1'b1, 1'b0, 2'd1, 8'h00);
      step(); step();
      chk("t36_ack",   32'(bus.ack),   32'h1);
      chk("t36_rdata", 32'(bus.rdata), 32'h00);
      bus.req = '0;
      step(); step();

      // Winner holds req five cycles past its ack while requester 2 waits.
      do_reset();
      set_slot(0, 1'b1, 1'b0, 2'd0, 8'h00);
      set_slot(2, 1'b1, 1'b0, 2'd1, 8'h00);
      nack = 0;
      step();
      chk("t37_gnt", 32'(bus.gnt), 32'h1);
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.ack) nack++;
         chk($sformatf("t37_hold%0d", k), 32'(bus.gnt), 32'h1);
      end
      chk("t37_acks", 32'(nack), 32'd1);
      bus.req[0] = 1'b0;
      step();
      chk("t37_clr", 32'(bus.gnt), 32'h0);
      step();
      chk("t37_next", 32'(bus.gnt), 32'h4);
      bus.req = '0;
      step(); step();

      // Random traffic: requests, holds, withdrawals/aborts and occasional resets.
      do_reset();
      done_r = '0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            bus.req = '0;
            done_r = '0;
            step();
            rst_n = 1'b1;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (bus.gnt[i] && bus.ack) done_r[i] = 1'b1;
               if (!bus.req[i]) begin
                  if ($urandom_range(0, 2) == 0)
                     set_slot(i, 1'b1, 1'($urandom_range(0, 1)),
                              AW'($urandom_range(0, D - 1)), W'($urandom_range(0, 255)));
               end else if (done_r[i]) begin
                  if ($urandom_range(0, 1) == 0) begin
                     bus.req[i] = 1'b0;
                     done_r[i] = 1'b0;
                  end
               end else if ($urandom_range(0, 15) == 0) begin
                  bus.req[i] = 1'b0;
               end
            end
         end
      end
      bus.req = '0;
      step(); step(); step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: data width of each storage register.
REQ-003 Parameter DEPTH, default 4, power of two: number of registers in the shared bank; AW = log2(DEPTH).
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 req  input  N_REQ: per-requester access request, level, 4-phase handshake.
REQ-007 we  input  N_REQ: per-requester op select; 1 = write, 0 = read.
REQ-008 addr  input  N_REQ*AW: per-requester register index; slice i is [i*AW +: AW].
REQ-009 wdata  input  N_REQ*WIDTH: per-requester write data; slice i is [i*WIDTH +: WIDTH].
REQ-010 gnt  output  N_REQ: one-hot grant, registered.
REQ-011 ack  output  1: one-cycle pulse, registered; marks completion of the granted access.
REQ-012 rdata  output  WIDTH: read data, registered; valid in the ack cycle, held until the next read.
REQ-013 busy  output  1: high in any state other than IDLE.

Function
REQ-014 The block SHALL contain DEPTH x WIDTH edge-triggered storage registers, written only through the granted port.
REQ-015 FSM states SHALL be IDLE, GRANT and DONE; the encoding is free.
REQ-016 IDLE: at an edge with any req bit high, the FSM SHALL select the winner, set gnt to the winner's one-hot value and go to GRANT; with no req high it SHALL stay in IDLE.
REQ-017 Winner selection SHALL be round-robin: the lowest index i >= ptr with req[i]=1; if none exists, the lowest index overall; ptr is an AW-independent pointer of width log2(N_REQ).
REQ-018 GRANT, winner w with req[w]=1 at the edge: the FSM SHALL perform the access using we[w], addr[w] and wdata[w] sampled at that edge, pulse ack, and go to DONE.
REQ-019 On a write, the FSM SHALL load bank[addr[w]] with wdata[w]; rdata is unchanged.
REQ-020 On a read, the FSM SHALL load rdata with bank[addr[w]]; the bank is unchanged.
REQ-021 GRANT with req[w]=0 at the edge (abort): no access, no ack, gnt SHALL clear, ptr SHALL become w+1 mod N_REQ, and the FSM SHALL go to IDLE.
REQ-022 DONE: gnt SHALL stay asserted until req[w] is sampled low; at that edge gnt SHALL clear, ptr SHALL become w+1 mod N_REQ, and the FSM SHALL go to IDLE.
REQ-023 Latency: req is sampled at edge E0, gnt is high after E0, ack is high for the single cycle after E1, and gnt is low no earlier than after E2.
REQ-024 Requests from non-winners SHALL be ignored until the FSM returns to IDLE; there is no preemption.
REQ-025 Minimum spacing between two grants SHALL be 3 cycles (GRANT, DONE, IDLE).
REQ-026 ack SHALL never be high in two consecutive cycles.
REQ-027 At most one gnt bit SHALL be high in any cycle.
REQ-028 addr values are always in range because DEPTH is a power of two; no wrap handling is needed.

Reset
REQ-029 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, gnt=0, ack=0, busy=0, rdata=0, ptr=0, and all bank registers=0.
REQ-030 Reset asserted mid-transaction SHALL discard the transaction: no write, no ack after release.
REQ-031 After rst_n rises, the first grant SHALL be possible at the first edge that samples req high.

Verification
REQ-032 Single write then read: req[1] with we=1, addr=2, wdata=0xA5, then a read of addr 2 -> gnt=0010 after E0, ack after E1, then rdata=0xA5 in the read's ack cycle.
REQ-033 Simultaneous requests: req=1111 held, each requester dropping req after its ack -> grant order 0,1,2,3,0; every gnt one-hot; 4 acks.
REQ-034 Round-robin pointer: serve req[2] first, then raise req=1001 -> the next grant goes to 3, then to 0.
REQ-035 Abort: req[0] dropped at the GRANT edge -> no ack, bank unchanged, busy low one cycle later, ptr=1.
REQ-036 Reset mid-operation: assert rst_n=0 in the cycle after a write-grant to addr 1 -> gnt, ack and busy fall without a clock edge; bank[1] reads 0x00 after reset.
REQ-037 Hold: the winner keeps req high for 5 cycles after ack -> gnt stays high for those cycles, exactly one ack, and no other requester is granted.
